// File: rtl/wasm_core_if.sv
// Byte-fetch port between wasm_core (master) and the program memory (slave).
// Request/valid handshake: the request and address are held until the valid strobe.
interface wasm_core_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;
   logic              mem_valid;

   modport master (output mem_req, mem_addr, input mem_data, mem_valid);
   modport slave  (input mem_req, mem_addr, output mem_data, mem_valid);
endinterface

// File: rtl/wasm_core.sv
// Byte-serial WebAssembly interpreter core with a typed 66-bit-entry operand stack.
// Define WASM_I64_EN to enable i64.const (0x42) and i64.add (0x7C); otherwise they trap as unknown.
module wasm_core #(
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       STACK_DEPTH = 16,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic               clk,
   input  logic               reset,
   wasm_core_if.master        mem,
   output logic [63:0]        result,
   output logic               result_empty,
   output logic               result_valid,
   output logic               halted,
   output logic [2:0]         trap
);
   localparam int unsigned SW  = $clog2(STACK_DEPTH);
   localparam int unsigned SPW = SW + 1;
   localparam logic [1:0]  T_I32 = 2'd1;
   localparam logic [1:0]  T_I64 = 2'd2;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_IMM, S_EXEC, S_HALT, S_TRAP} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, addr, addr_n;
   logic              req, req_n;
   logic [7:0]        op, op_n;
   logic [3:0]        nb, nb_n;
   logic [63:0]       acc, acc_n, imm, imm_n;
   logic [SPW-1:0]    sp, sp_n, sp_m1, sp_m2, sp_m3;
   logic [65:0]       stk [STACK_DEPTH];
   logic [65:0]       tos, nos, thd, wr_data;
   logic [SW-1:0]     wr_idx;
   logic              wr_en;
   logic [63:0]       result_n;
   logic              empty_n, rvalid_n;
   logic [2:0]        trap_n, fault;
   logic [6:0]        sh7, sh;
   logic [63:0]       shl, ext;
   logic [31:0]       sum32;
   logic              last_byte;

   assign mem.mem_req  = req;
   assign mem.mem_addr = addr;
   assign halted       = (state == S_HALT) || (state == S_TRAP);

   assign sp_m1 = sp - SPW'(1);
   assign sp_m2 = sp - SPW'(2);
   assign sp_m3 = sp - SPW'(3);
   assign tos   = stk[sp_m1[SW-1:0]];
   assign nos   = stk[sp_m2[SW-1:0]];
   assign thd   = stk[sp_m3[SW-1:0]];
   assign sum32 = (op == 8'h6B) ? (nos[31:0] - tos[31:0]) : (nos[31:0] + tos[31:0]);

   always_comb begin
      state_n   = state;
      pc_n      = pc;
      addr_n    = addr;
      req_n     = req;
      op_n      = op;
      nb_n      = nb;
      acc_n     = acc;
      imm_n     = imm;
      sp_n      = sp;
      result_n  = result;
      empty_n   = result_empty;
      rvalid_n  = 1'b0;
      trap_n    = trap;
      fault     = 3'd0;
      wr_en     = 1'b0;
      wr_idx    = sp[SW-1:0];
      wr_data   = '0;
      sh7       = {nb, 3'b000} - {3'b000, nb};
      sh        = 7'd57 - sh7;
      shl       = '0;
      ext       = '0;
      last_byte = (op == 8'h41) ? (nb == 4'd4) : (nb == 4'd9);

      unique case (state)
         S_FETCH: begin
            if (!req) begin
               req_n  = 1'b1;
               addr_n = pc;
            end else if (mem.mem_valid) begin
               req_n   = 1'b0;
               pc_n    = pc + ADDR_W'(1);
               op_n    = mem.mem_data;
               state_n = S_DECODE;
            end
         end
         S_DECODE: begin
            nb_n    = '0;
            acc_n   = '0;
            state_n = S_EXEC;
            case (op)
               8'h00: fault = 3'd3;
               8'h01, 8'h0B, 8'h1A, 8'h1B, 8'h45, 8'h6A, 8'h6B: state_n = S_EXEC;
               8'h41: state_n = S_IMM;
`ifdef WASM_I64_EN
               8'h42: state_n = S_IMM;
               8'h7C: state_n = S_EXEC;
`endif
               default: fault = 3'd4;
            endcase
         end
         S_IMM: begin
            if (!req) begin
               req_n  = 1'b1;
               addr_n = pc;
            end else if (mem.mem_valid) begin
               req_n = 1'b0;
               pc_n  = pc + ADDR_W'(1);
               nb_n  = nb + 4'd1;
               acc_n = acc | ({57'd0, mem.mem_data[6:0]} << sh7);
               // Final byte: continuation is illegal and bits beyond the value width must match its sign.
               if (last_byte) begin
                  if (mem.mem_data[7])
                     fault = 3'd6;
                  else if (op == 8'h41 && mem.mem_data[6:4] != {3{mem.mem_data[3]}})
                     fault = 3'd6;
`ifdef WASM_I64_EN
                  else if (op == 8'h42 && mem.mem_data[6:1] != {6{mem.mem_data[0]}})
                     fault = 3'd6;
`endif
               end
               if (!mem.mem_data[7]) begin
                  if (nb == 4'd9) begin
                     ext = acc_n;
                  end else begin
                     shl = acc_n << sh;
                     ext = $unsigned($signed(shl) >>> sh);
                  end
                  imm_n   = (op == 8'h41) ? {32'd0, ext[31:0]} : ext;
                  state_n = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            state_n = S_FETCH;
            case (op)
               8'h0B: begin
                  result_n = (sp == '0) ? 64'd0 : tos[63:0];
                  empty_n  = (sp == '0);
                  rvalid_n = 1'b1;
                  state_n  = S_HALT;
               end
               8'h1A: begin
                  if (sp == '0) fault = 3'd2;
                  else          sp_n  = sp_m1;
               end
               8'h41, 8'h42: begin
                  if (sp == SPW'(STACK_DEPTH)) begin
                     fault = 3'd1;
                  end else begin
                     wr_en   = 1'b1;
                     wr_data = {(op == 8'h41) ? T_I32 : T_I64, imm};
                     sp_n    = sp + SPW'(1);
                  end
               end
               8'h45: begin
                  if (sp == '0)                fault = 3'd2;
                  else if (tos[65:64] != T_I32) fault = 3'd5;
                  else begin
                     wr_en   = 1'b1;
                     wr_idx  = sp_m1[SW-1:0];
                     wr_data = {T_I32, 63'd0, tos[31:0] == 32'd0};
                  end
               end
               8'h6A, 8'h6B: begin
                  if (sp < SPW'(2))                                    fault = 3'd2;
                  else if (tos[65:64] != T_I32 || nos[65:64] != T_I32) fault = 3'd5;
                  else begin
                     wr_en   = 1'b1;
                     wr_idx  = sp_m2[SW-1:0];
                     wr_data = {T_I32, 32'd0, sum32};
                     sp_n    = sp_m1;
                  end
               end
`ifdef WASM_I64_EN
               8'h7C: begin
                  if (sp < SPW'(2))                                    fault = 3'd2;
                  else if (tos[65:64] != T_I64 || nos[65:64] != T_I64) fault = 3'd5;
                  else begin
                     wr_en   = 1'b1;
                     wr_idx  = sp_m2[SW-1:0];
                     wr_data = {T_I64, nos[63:0] + tos[63:0]};
                     sp_n    = sp_m1;
                  end
               end
`endif
               8'h1B: begin
                  if (sp < SPW'(3))                                         fault = 3'd2;
                  else if (tos[65:64] != T_I32 || nos[65:64] != thd[65:64]) fault = 3'd5;
                  else begin
                     wr_en   = 1'b1;
                     wr_idx  = sp_m3[SW-1:0];
                     wr_data = (tos[31:0] != 32'd0) ? thd : nos;
                     sp_n    = sp_m2;
                  end
               end
               default: state_n = S_FETCH;
            endcase
         end
         default: state_n = state;
      endcase

      // Any fault cancels the stack update and freezes the core.
      if (fault != 3'd0) begin
         trap_n  = fault;
         state_n = S_TRAP;
         req_n   = 1'b0;
         wr_en   = 1'b0;
         sp_n    = sp;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_FETCH;
         pc           <= RESET_PC;
         addr         <= '0;
         req          <= 1'b0;
         op           <= '0;
         nb           <= '0;
         acc          <= '0;
         imm          <= '0;
         sp           <= '0;
         result       <= '0;
         result_empty <= 1'b1;
         result_valid <= 1'b0;
         trap         <= '0;
      end else begin
         state        <= state_n;
         pc           <= pc_n;
         addr         <= addr_n;
         req          <= req_n;
         op           <= op_n;
         nb           <= nb_n;
         acc          <= acc_n;
         imm          <= imm_n;
         sp           <= sp_n;
         result       <= result_n;
         result_empty <= empty_n;
         result_valid <= rvalid_n;
         trap         <= trap_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && wr_en) stk[wr_idx] <= wr_data;
   end
endmodule

// File: tb/tb_wasm_core.sv
// Randomised self-checking bench for wasm_core against a queue-based interpreter model.
// Honours WASM_I64_EN the same way as the design.
module tb_wasm_core;
   localparam int unsigned STACK_DEPTH = 16;
`ifdef WASM_I64_EN
   localparam bit I64_EN = 1'b1;
`else
   localparam bit I64_EN = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  ty;
      logic [63:0] v;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] result;
   logic        result_empty, result_valid, halted;
   logic [2:0]  trap;

   logic [7:0]  img [256];
   logic [7:0]  prog [$];
   int          lat_mode = 0;
   bit          inject = 1'b0;
   int          bytes_seen = 0;
   int          pulses = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   wasm_core_if #(.ADDR_W(16)) bus ();

   wasm_core #(.ADDR_W(16), .STACK_DEPTH(STACK_DEPTH), .RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem          (bus),
      .result       (result),
      .result_empty (result_empty),
      .result_valid (result_valid),
      .halted       (halted),
      .trap         (trap)
   );

   // Memory responder: acts 2 time units after each rising edge, with per-byte latency.
   initial begin
      int wcnt;
      int cur_lat;
      wcnt          = 0;
      cur_lat       = 0;
      bus.mem_valid = 1'b0;
      bus.mem_data  = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         if (!reset) begin
            bytes_seen = 0;
            pulses     = 0;
         end else if (result_valid) begin
            pulses++;
         end
         if (inject) begin
            bus.mem_valid = 1'b1;
            bus.mem_data  = 8'h00;
            wcnt          = 0;
         end else if (bus.mem_req && !bus.mem_valid) begin
            if (wcnt >= cur_lat) begin
               bus.mem_valid = 1'b1;
               bus.mem_data  = img[bus.mem_addr[7:0]];
               if (reset) bytes_seen++;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            bus.mem_valid = 1'b0;
            wcnt          = 0;
            cur_lat       = (lat_mode < 0) ? int'($urandom_range(0, 4)) : lat_mode;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_prog();
      foreach (img[i]) img[i] = 8'h00;
      foreach (prog[i]) img[i] = prog[i];
   endtask

   // Interpreter over img following the instruction-set rules directly.
   function automatic void model_run(output logic [2:0] et, output logic [63:0] er,
                                     output logic ee, output int ends, output int used);
      ent_t        st [$];
      ent_t        a, b, c;
      int          pc, n, maxb, sz;
      logic [7:0]  op, bt;
      logic [63:0] acc, r;
      bit          wide;
      et = 3'd0; er = 64'd0; ee = 1'b1; ends = 0; pc = 0;
      for (int steps = 0; steps < 400 && et == 3'd0 && ends == 0; steps++) begin
         op = img[pc % 256]; pc++;
         wide = (op == 8'h42) || (op == 8'h7C);
         sz = st.size();
         if (wide && !I64_EN) et = 3'd4;
         else case (op)
            8'h00: et = 3'd3;
            8'h01: ;
            8'h0B: begin
               ends = 1;
               ee   = (sz == 0);
               er   = (sz == 0) ? 64'd0 : st[sz-1].v;
            end
            8'h1A: if (sz < 1) et = 3'd2; else void'(st.pop_back());
            8'h41, 8'h42: begin
               maxb = wide ? 10 : 5; acc = 64'd0; n = 0;
               do begin
                  bt = img[pc % 256]; pc++;
                  acc = acc | (64'(bt[6:0]) << (7 * n));
                  n++;
                  if (n == maxb && (bt[7] ||
                      (wide ? (bt[6:1] != {6{bt[0]}}) : (bt[6:4] != {3{bt[3]}}))))
                     et = 3'd6;
               end while (bt[7] && et == 3'd0);
               if (et == 3'd0) begin
                  if (7 * n < 64 && acc[7 * n - 1]) acc = acc | (~64'd0 << (7 * n));
                  if (sz >= STACK_DEPTH) et = 3'd1;
                  else begin
                     a = wide ? {2'd2, acc} : {2'd1, 32'd0, acc[31:0]};
                     st.push_back(a);
                  end
               end
            end
            8'h45: begin
               if (sz < 1) et = 3'd2;
               else if (st[sz-1].ty != 2'd1) et = 3'd5;
               else st[sz-1] = {2'd1, (st[sz-1].v[31:0] == 32'd0) ? 64'd1 : 64'd0};
            end
            8'h6A, 8'h6B, 8'h7C: begin
               if (sz < 2) et = 3'd2;
               else begin
                  b = st[sz-1]; a = st[sz-2];
                  if (a.ty != (wide ? 2'd2 : 2'd1) || b.ty != a.ty) et = 3'd5;
                  else begin
                     if (op == 8'h6A)      r = (a.v + b.v) & 64'hFFFF_FFFF;
                     else if (op == 8'h6B) r = (a.v - b.v) & 64'hFFFF_FFFF;
                     else                  r = a.v + b.v;
                     void'(st.pop_back()); void'(st.pop_back());
                     st.push_back({a.ty, r});
                  end
               end
            end
            8'h1B: begin
               if (sz < 3) et = 3'd2;
               else begin
                  c = st[sz-1]; b = st[sz-2]; a = st[sz-3];
                  if (c.ty != 2'd1 || a.ty != b.ty) et = 3'd5;
                  else begin
                     repeat (3) void'(st.pop_back());
                     st.push_back((c.v[31:0] != 32'd0) ? a : b);
                  end
               end
            end
            default: et = 3'd4;
         endcase
      end
      used = pc;
   endfunction

   task automatic start_prog();
      @(negedge clk) reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic finish_prog(input string tag);
      logic [2:0]  et;
      logic [63:0] er;
      logic        ee;
      int          ends, used, cyc;
      model_run(et, er, ee, ends, used);
      cyc = 0;
      while (!halted && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (4) @(negedge clk);
      check($sformatf("%s_halt", tag), 64'(halted), 64'd1);
      check($sformatf("%s_trap", tag), 64'(trap), 64'(et));
      check($sformatf("%s_result", tag), result, er);
      check($sformatf("%s_empty", tag), 64'(result_empty), 64'(ee));
      check($sformatf("%s_pulses", tag), 64'(pulses), 64'(ends));
      check($sformatf("%s_bytes", tag), 64'(bytes_seen), 64'(used));
      check($sformatf("%s_req", tag), 64'(bus.mem_req), 64'd0);
   endtask

   task automatic run_prog(input string tag);
      load_prog();
      start_prog();
      finish_prog(tag);
   endtask

   task automatic emit_const(input bit wide);
      longint     v;
      logic [7:0] b;
      bit         done;
      if (wide) v = longint'({$urandom, $urandom});
      else      v = longint'(int'($urandom));
      if ($urandom_range(0, 2) == 0) v = v >>> $urandom_range(20, 60);
      prog.push_back(wide ? 8'h42 : 8'h41);
      do begin
         b    = {1'b0, v[6:0]};
         v    = v >>> 7;
         done = (v == 0 && !b[6]) || (v == -1 && b[6]);
         if (!done) b[7] = 1'b1;
         prog.push_back(b);
      end while (!done);
   endtask

   task automatic gen_random();
      int r;
      prog = {};
      repeat (3) emit_const($urandom_range(0, 3) == 0);
      repeat ($urandom_range(2, 8)) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: emit_const($urandom_range(0, 3) == 0);
            3:       prog.push_back(8'h6A);
            4:       prog.push_back(8'h6B);
            5:       prog.push_back(8'h7C);
            6:       prog.push_back(8'h45);
            7:       prog.push_back(8'h1B);
            8:       prog.push_back(8'h1A);
            default: prog.push_back(8'h01);
         endcase
      end
      prog.push_back(8'h0B);
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      check("rst_req", 64'(bus.mem_req), 64'd0);
      check("rst_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_empty", 64'(result_empty), 64'd1);
      check("rst_valid", 64'(result_valid), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_trap", 64'(trap), 64'd0);

      lat_mode = 1;
      prog = '{8'h41, 8'h2A, 8'h0B};
      run_prog("const");
      check("const_lit", result, 64'h2A);
      check("const_pc", 64'(bytes_seen), 64'd3);

      prog = '{8'h41, 8'h7F, 8'h41, 8'h03, 8'h6A, 8'h0B};
      for (int l = 0; l <= 4; l++) begin
         lat_mode = l;
         run_prog($sformatf("add_lat%0d", l));
         check($sformatf("add_lat%0d_lit", l), result, 64'd2);
      end

      lat_mode = -1;
      prog = '{8'h41, 8'h05, 8'h41, 8'h07, 8'h41, 8'h00, 8'h1B, 8'h0B};
      run_prog("sel0");
      check("sel0_lit", result, 64'd7);
      prog = '{8'h41, 8'h05, 8'h41, 8'h07, 8'h41, 8'h01, 8'h1B, 8'h0B};
      run_prog("sel1");
      check("sel1_lit", result, 64'd5);
      prog = '{8'h42, 8'h01, 8'h41, 8'h01, 8'h41, 8'h01, 8'h1B, 8'h0B};
      run_prog("sel_mix");
      check("sel_mix_lit", 64'(trap), I64_EN ? 64'd5 : 64'd4);

      prog = {};
      repeat (STACK_DEPTH + 1) begin
         prog.push_back(8'h41);
         prog.push_back(8'h00);
      end
      run_prog("ovf");
      check("ovf_lit", 64'(trap), 64'd1);
      check("ovf_sp", 64'(dut.sp), 64'(STACK_DEPTH));
      prog = '{8'h1A};
      run_prog("unf");
      check("unf_lit", 64'(trap), 64'd2);
      prog = '{8'h00};
      run_prog("unreach");
      check("unreach_lit", 64'(trap), 64'd3);
      prog = '{8'hFF};
      run_prog("unknown");
      check("unknown_lit", 64'(trap), 64'd4);
      prog = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h10};
      run_prog("leb_bad");
      check("leb_bad_lit", 64'(trap), 64'd6);
      prog = '{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h0B};
      run_prog("leb_long");
      check("leb_long_lit", 64'(trap), 64'd6);
      prog = '{8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h0B};
      run_prog("leb_max");
      check("leb_max_lit", result, 64'h7FFF_FFFF);
      prog = '{8'h42, 8'h00, 8'h0B};
      run_prog("i64c");
      check("i64c_lit", 64'(trap), I64_EN ? 64'd0 : 64'd4);
      prog = '{8'h0B};
      run_prog("empty_end");
      check("empty_end_lit", 64'(result_empty), 64'd1);

      // Reset while a fetch is outstanding, with a stray valid strobe during reset.
      prog = '{8'h41, 8'h2A, 8'h0B};
      load_prog();
      lat_mode = 10000;
      start_prog();
      cyc = 0;
      while (!bus.mem_req && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("mr_req_up", 64'(bus.mem_req), 64'd1);
      check("mr_addr", 64'(bus.mem_addr), 64'd0);
      reset  = 1'b0;
      inject = 1'b1;
      @(negedge clk);
      check("mr_req_drop", 64'(bus.mem_req), 64'd0);
      check("mr_halted", 64'(halted), 64'd0);
      check("mr_trap", 64'(trap), 64'd0);
      check("mr_empty", 64'(result_empty), 64'd1);
      @(negedge clk);
      reset    = 1'b1;
      inject   = 1'b0;
      lat_mode = 1;
      finish_prog("midreset");
      check("midreset_lit", result, 64'h2A);

      lat_mode = -1;
      for (int t = 0; t < 40; t++) begin
         gen_random();
         run_prog($sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/wasm_core.md
Name: wasm_core

Overview:
- Parametrised successor CPU: byte-serial WebAssembly interpreter core with an internal typed operand stack.
- Configurable stack depth and address width.
- Fetches bytes over a variable-latency request/valid memory port and decodes signed LEB128 immediates one byte at a time.
- Reports end-of-program results and numbered traps; intended as the execution engine behind the program ROM.

Parameters:
ADDR_W, 16, program byte-address width; PC wraps modulo 2**ADDR_W
STACK_DEPTH, 16, operand stack entries (power of 2, >=4); each entry is 2-bit type + 64-bit value
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
mem_req  output  1  byte fetch request
mem_addr  output  ADDR_W  byte address; stable while mem_req=1
mem_data  input  8  fetched byte, sampled when mem_req&mem_valid
mem_valid  input  1  response strobe; ignored while mem_req=0
result  output  64  top-of-stack value latched at end
result_empty  output  1  stack was empty at end
result_valid  output  1  one-cycle pulse when result is updated
halted  output  1  core stopped (end executed or trap)
trap  output  3  0 none, 1 overflow, 2 underflow, 3 unreachable, 4 unknown opcode, 5 type mismatch, 6 malformed LEB128

Behaviour:
- Reset (reset=0 at a clock edge): PC=RESET_PC, sp=0, state=FETCH, mem_req=0, mem_addr=0, result=0, result_empty=1, result_valid=0, halted=0, trap=0. Reset mid-fetch drops the request; a late mem_valid is ignored because mem_req=0.
- Handshake: mem_req rises with mem_addr=PC; both are held until the cycle mem_valid=1; the byte is accepted that edge; mem_req drops next cycle; PC increments by 1 per accepted byte (wraps). Minimum 2 cycles per byte.
- States: FETCH -> DECODE -> (IMM)* -> EXEC -> FETCH; HALT and TRAP are terminal until reset.
- DECODE opcodes:
  - 0x00 unreachable -> trap 3.
  - 0x01 nop.
  - 0x0B end.
  - 0x1A drop.
  - 0x1B select.
  - 0x41 i32.const.
  - 0x42 i64.const.
  - 0x45 i32.eqz.
  - 0x6A i32.add.
  - 0x6B i32.sub.
  - 0x7C i64.add.
  - Anything else -> trap 4.
- IMM: one fetch per LEB128 byte; accumulate byte[6:0]<<(7*n); stop on bit7=0; sign-extend from bit 7n+6.
  - i32: max 5 bytes. On the 5th byte, bit7=1 -> trap 6. Unused bits [6:4] must equal the sign (bit 3), else trap 6.
  - i64: max 10 bytes. Same rule: on the 10th byte, bits [6:1] must equal bit 0.
  - Pushed as {type, value}; i32 values stored zero-extended in [63:32].
- EXEC, one cycle:
  - drop: pop 1.
  - eqz: tos must be i32; replaced by 1 if [31:0]==0, else 0.
  - add/sub: pop b (tos), pop a, push a op b modulo 2^32 / 2^64. Both operands must be the opcode type, else trap 5.
  - select: c=tos (must be i32), v2, v1; v1/v2 types must match (trap 5); result = c[31:0]!=0 ? v1 : v2; net sp-2.
  - end: result <= tos value (0 if empty); result_empty <= (sp==0); result_valid pulse; halted=1.
- Stack checks happen before any write:
  - Underflow (sp < operands needed) -> trap 2.
  - Push with sp==STACK_DEPTH -> trap 1.
  - Stack is not modified on a faulting op.
- Trap: trap code is set, halted=1 the same edge, mem_req=0; all state frozen; first trap wins.

Optional Feature:
- WASM_I64_EN defined: 0x42 and 0x7C execute as above.
- Undefined: both decode as unknown (trap 4); i64 LEB path and 64-bit adder omitted; entries still 66 bits.

Test Plan:
- Bytes 41 2A 0B, mem_valid 1 cycle after req -> result=0x2A, result_empty=0, result_valid one pulse, halted=1, trap=0, PC=3.
- 41 7F 41 03 6A 0B -> result=0x0000_0000_0000_0002 (-1+3); repeat with mem_valid latency 0..4 cycles -> same result.
- 41 05 41 07 41 00 1B 0B -> result=7; with condition byte 01 -> result=5; 42 01 41 01 41 01 1B (WASM_I64_EN) -> trap 5.
- Push STACK_DEPTH+1 i32.const 00 -> trap 1 at the last push, sp=STACK_DEPTH; 1A on empty stack -> trap 2; 00 -> trap 3; FF -> trap 4.
- 41 80 80 80 80 10 -> trap 6; 41 FF FF FF FF 07 0B -> result=0x7FFFFFFF; without WASM_I64_EN, 42 00 -> trap 4.
- Assert reset=0 while mem_req=1, then return mem_valid -> ignored; after release, fetch restarts at RESET_PC with all outputs at reset values.
